rtc_bus_burst_sequencer: RTL
============================

Name: rtc_bus_burst_sequencer

Overview:
Parametrised successor to the single-access RTC read/write pulse generator. It executes a burst of 1..MAX_BURST consecutive register accesses on the multiplexed address/data RTC bus (a_d, cs, rd, wr) with programmable phase timing and per-word read/write data handshakes. It sits between the general RTC FSM, which issues bursts, and the tri-state pad logic at the top level. Bursts can be aborted.

Parameters:
DATA_W, 8, bus width; address and data share the bus.
MAX_BURST, 16, maximum words per burst.
PHASE_CYC, 4, clk cycles per bus phase; minimum 1.
LEN_W, $clog2(MAX_BURST+1), width of the length field.

Ports:
clk  in  1  system clock; all logic rises on this edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle burst request; accepted only while busy=0.
wr_mode  in  1  1 = write burst, 0 = read burst; sampled with start.
start_addr  in  DATA_W  first RTC register address; sampled with start.
len  in  LEN_W  word count; sampled with start.
abort  in  1  requests early termination.
wdata  in  DATA_W  write data for the current word_idx.
bus_in  in  DATA_W  value read back from the RTC data pads.
bus_out  out  DATA_W  value driven onto the pads.
bus_oe  out  1  pad output enable.
a_d  out  1  0 = address phase, 1 = data phase.
cs  out  1  active-low chip select.
rd  out  1  active-low read strobe.
wr  out  1  active-low write strobe.
word_idx  out  LEN_W  index of the word in flight.
cur_addr  out  DATA_W  address of the word in flight.
rdata  out  DATA_W  last word read.
rvalid  out  1  one-cycle pulse when rdata updates.
busy  out  1  burst in progress.
done  out  1  one-cycle pulse at burst end.
aborted  out  1  done was caused by abort; holds until the next start.

Behaviour:
- Reset values: a_d=1, cs=1, rd=1, wr=1, bus_oe=0, bus_out=0, busy=0, done=0, rvalid=0, aborted=0, rdata=0, word_idx=0, cur_addr=0, state=IDLE.
- Reset asserted mid-burst: the next cycle shows the reset values; no partial word completes.
- States: IDLE, ADDR_ASSERT, ADDR_HOLD, DATA_ASSERT, DATA_HOLD, GAP, FINISH. Every state except IDLE and FINISH lasts exactly PHASE_CYC cycles.
- IDLE, start=1 with len>0:
  - Latch wr_mode, start_addr and min(len, MAX_BURST).
  - Set word_idx=0 and busy=1, then go to ADDR_ASSERT.
  - start while busy=1 is ignored.
- len=0: go straight to FINISH, so done pulses on the cycle after start and no strobe toggles.
- ADDR_ASSERT: cs=0, wr=0, a_d=0, bus_oe=1, bus_out=cur_addr.
- ADDR_HOLD: wr=1, cs=0, a_d=0; bus keeps driving cur_addr.
- Entry to DATA_ASSERT: a_d=1, cs=0.
  - Write burst: wr=0, bus_oe=1, bus_out=wdata. wdata is sampled once, on the entry cycle, and held for the rest of the word.
  - Read burst: rd=0, bus_oe=0.
- Read burst, last DATA_ASSERT cycle: bus_in is captured into rdata. rvalid pulses on the first DATA_HOLD cycle.
- DATA_HOLD: rd=1, wr=1, cs=0, a_d=1. A write burst keeps driving data; a read burst keeps bus_oe=0.
- GAP: cs=1, a_d=1, bus_oe=0. On the last GAP cycle:
  - If words remain and abort has not been latched: word_idx+1, go to ADDR_ASSERT.
  - Otherwise go to FINISH.
- cur_addr = start_addr + word_idx, modulo 2^DATA_W (0xFF wraps to 0x00).
- FINISH: one cycle. done=1, busy=0, then back to IDLE.
- Latency: done is high in cycle 1 + 5·PHASE_CYC·N after the start cycle (cycle 0).
- abort: latched in any busy state. The word in flight always completes its full five phases, with no truncated strobes. The burst then ends at FINISH with aborted=1. abort in IDLE is ignored.
- start together with abort in IDLE: start wins and the abort is dropped.
- rd and wr are never low in the same cycle.
- wr low during the address phase is the RTC address-latch strobe.

Decomposition:
- Package rtc_bus_pkg holds:
  - the state enum;
  - default PHASE_CYC and MAX_BURST;
  - named RTC command addresses (transfer-to-RAM/clock, e.g. 8'hF0/8'hF1/8'hF2) used by the issuing FSM.
- Sub-module rtc_phase_timer: down-counter of width $clog2(PHASE_CYC+1). It reloads on state entry and outputs last_cycle. One instance only.

Test Plan:
- Write burst, PHASE_CYC=2, start_addr=8'h21, len=3, wdata = 8'h10 + word_idx:
  - address phases drive 21/22/23; data phases drive 10/11/12;
  - wr is low 2 cycles in each address and data phase;
  - done at cycle 31, aborted=0.
- Read burst, PHASE_CYC=1, start_addr=8'h41, len=2, bus_in 8'h59 then 8'h07:
  - rvalid twice, rdata 59 then 07;
  - bus_oe=0 throughout both data phases; done at cycle 11.
- start_addr=8'hFF, len=2 -> cur_addr FF then 00.
- len=0 -> done at cycle 1; cs, rd and wr stay 1 throughout. len=20 with MAX_BURST=16 -> exactly 16 words.
- Abort:
  - abort pulsed during word 1 DATA_ASSERT of a len=4 burst -> word 1 completes, done with aborted=1, word_idx=1, no word-2 strobes;
  - start pulsed while busy -> ignored.
- Reset asserted during DATA_ASSERT of a write -> next cycle cs=1, wr=1, bus_oe=0, busy=0; a following start runs normally.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus burst sequencer and
// the FSM that issues its bursts.
package rtc_bus_pkg;

  localparam int DEF_PHASE_CYC = 4;
  localparam int DEF_MAX_BURST = 16;

  // Command registers that trigger transfers between the RTC RAM and the clock core.
  localparam logic [7:0] RTC_CMD_XFER_TO_RAM   = 8'hF0;
  localparam logic [7:0] RTC_CMD_XFER_TO_CLOCK = 8'hF1;
  localparam logic [7:0] RTC_CMD_XFER_ALARM    = 8'hF2;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_ASSERT,
    ADDR_HOLD,
    DATA_ASSERT,
    DATA_HOLD,
    GAP,
    FINISH
  } state_e;

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase-length down-counter: reloads whenever the sequencer enters a new
// state and flags the final cycle of that phase.
module rtc_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYC = DEF_PHASE_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  output logic last_cycle_o
);

  localparam int CW = $clog2(PHASE_CYC + 1);
  localparam logic [CW-1:0] RELOAD = CW'(PHASE_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= RELOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign last_cycle_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_burst_sequencer.sv
// Burst sequencer for the multiplexed address/data RTC bus: runs 1..MAX_BURST
// register accesses with five timed phases per word and supports abort.
module rtc_bus_burst_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int PHASE_CYC = DEF_PHASE_CYC,
  parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_mode,
  input  logic [DATA_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              a_d,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic [LEN_W-1:0]  word_idx,
  output logic [DATA_W-1:0] cur_addr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  state_e              state_q;
  logic                wr_mode_q;
  logic [DATA_W-1:0]   start_addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    word_idx_q;
  logic                abort_q;
  logic [DATA_W-1:0]   bus_out_q;
  logic                bus_oe_q;
  logic                a_d_q;
  logic                cs_q;
  logic                rd_q;
  logic                wr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                busy_q;
  logic                done_q;
  logic                aborted_q;

  logic [LEN_W-1:0]    len_clamp_d;
  logic [LEN_W-1:0]    word_next_d;
  logic [DATA_W-1:0]   next_addr_d;
  logic                more_words_d;
  logic                abort_seen_d;
  logic                phase_load;
  logic                last_cycle;

  assign len_clamp_d  = (len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : len;
  assign word_next_d  = word_idx_q + LEN_W'(1);
  assign next_addr_d  = start_addr_q + DATA_W'(word_next_d);
  assign more_words_d = (word_next_d < len_q);
  // An abort arriving on the very last GAP cycle still stops the burst.
  assign abort_seen_d = abort_q | abort;
  assign phase_load   = last_cycle || (state_q == IDLE) || (state_q == FINISH);

  rtc_phase_timer #(
    .PHASE_CYC(PHASE_CYC)
  ) u_phase_timer (
    .clk         (clk),
    .reset       (reset),
    .load_i      (phase_load),
    .last_cycle_o(last_cycle)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_mode_q    <= 1'b0;
      start_addr_q <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      abort_q      <= 1'b0;
      bus_out_q    <= '0;
      bus_oe_q     <= 1'b0;
      a_d_q        <= 1'b1;
      cs_q         <= 1'b1;
      rd_q         <= 1'b1;
      wr_q         <= 1'b1;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      if (busy_q && abort) begin
        abort_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            aborted_q <= 1'b0;
            abort_q   <= 1'b0;
            if (len == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              wr_mode_q    <= wr_mode;
              start_addr_q <= start_addr;
              len_q        <= len_clamp_d;
              word_idx_q   <= '0;
              busy_q       <= 1'b1;
              state_q      <= ADDR_ASSERT;
              cs_q         <= 1'b0;
              wr_q         <= 1'b0;
              a_d_q        <= 1'b0;
              bus_oe_q     <= 1'b1;
              bus_out_q    <= start_addr;
            end
          end
        end
        ADDR_ASSERT: begin
          if (last_cycle) begin
            state_q <= ADDR_HOLD;
            wr_q    <= 1'b1;
          end
        end
        ADDR_HOLD: begin
          if (last_cycle) begin
            state_q <= DATA_ASSERT;
            a_d_q   <= 1'b1;
            if (wr_mode_q) begin
              wr_q      <= 1'b0;
              bus_oe_q  <= 1'b1;
              bus_out_q <= wdata;
            end else begin
              rd_q     <= 1'b0;
              bus_oe_q <= 1'b0;
            end
          end
        end
        DATA_ASSERT: begin
          if (last_cycle) begin
            state_q <= DATA_HOLD;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            if (!wr_mode_q) begin
              rdata_q  <= bus_in;
              rvalid_q <= 1'b1;
            end
          end
        end
        DATA_HOLD: begin
          if (last_cycle) begin
            state_q  <= GAP;
            cs_q     <= 1'b1;
            bus_oe_q <= 1'b0;
          end
        end
        GAP: begin
          if (last_cycle) begin
            if (more_words_d && !abort_seen_d) begin
              word_idx_q <= word_next_d;
              state_q    <= ADDR_ASSERT;
              cs_q       <= 1'b0;
              wr_q       <= 1'b0;
              a_d_q      <= 1'b0;
              bus_oe_q   <= 1'b1;
              bus_out_q  <= next_addr_d;
            end else begin
              state_q   <= FINISH;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              aborted_q <= abort_seen_d;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_out  = bus_out_q;
  assign bus_oe   = bus_oe_q;
  assign a_d      = a_d_q;
  assign cs       = cs_q;
  assign rd       = rd_q;
  assign wr       = wr_q;
  assign word_idx = word_idx_q;
  assign cur_addr = start_addr_q + DATA_W'(word_idx_q);
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;

endmodule
